pe_mac8: RTL and testbench

Output-stationary processing element for the systolic convolution array, directly downstream of the 8-bit truncating multiplier `multu8`. It registers and forwards the activation operand east and the weight operand south, and feeds both registered operands to an instantiated `multu8`. It accumulates the 8-bit products over a window delimited by a `last` marker, then presents the window sum on a valid/ready result port.

---
 rtl/pe_mac8.sv | 189 ++++++++++++++++++
 tb/tb_pe_mac8.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac8.sv
// ---------------------------------------------------------------------------
// pe_mac8 - output-stationary processing element for the systolic conv array.
//
// Forwards the activation operand east and the weight operand south through
// one register stage. Both registered operands feed an 8-bit truncating
// multiplier (multu8). The products are accumulated over a window that ends
// on a last marker, and the window sum is presented on a valid/ready result
// port.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   a_in, b_in          activation / weight operands from west / north
//   valid_in, last_in   operand valid, final sample of window (qualified)
//   a_out, b_out        registered operands forwarded east / south
//   valid_out, last_out registered valid / (last & valid)
//   res_data            completed window sum (ACC_W bits)
//   res_count           samples in the completed window (saturating)
//   res_ovf             accumulator wrapped during that window
//   res_valid           result held and available
//   res_ready           consumer accepts the result
//   overrun             sticky: an unaccepted result was overwritten
//   clr_err             synchronous clear of overrun
// ---------------------------------------------------------------------------

// 8-bit truncating multiplier: low 8 bits of a*b.
//   i_a, i_b  operands
//   o_p       low byte of the product
module multu8 (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   output logic [7:0] o_p
);
   logic [15:0] w_prod;

   assign w_prod = 16'(i_a) * 16'(i_b);
   assign o_p    = w_prod[7:0];
endmodule

module pe_mac8 #(
   parameter int unsigned ACC_W = 20,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       a_in,
   input  logic [7:0]       b_in,
   input  logic             valid_in,
   input  logic             last_in,
   output logic [7:0]       a_out,
   output logic [7:0]       b_out,
   output logic             valid_out,
   output logic             last_out,
   output logic [ACC_W-1:0] res_data,
   output logic [CNT_W-1:0] res_count,
   output logic             res_ovf,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             overrun,
   input  logic             clr_err
);
   localparam int unsigned SUM_W = ACC_W + 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } state_t;

   // stage 1 registers
   logic [7:0]       r_a;
   logic [7:0]       r_b;
   logic             r_valid;
   logic             r_last;

   // stage 2 registers
   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic [ACC_W-1:0] r_res_data;
   logic [CNT_W-1:0] r_res_count;
   logic             r_res_ovf;
   logic             r_res_valid;
   logic             r_overrun;

   logic [7:0]       w_p;
   logic [ACC_W-1:0] w_acc_cur;
   logic [CNT_W-1:0] w_cnt_cur;
   logic             w_ovf_cur;
   logic [SUM_W-1:0] w_sum_full;
   logic [ACC_W-1:0] w_sum;
   logic [CNT_W-1:0] w_cnt_n;
   logic             w_ovf_n;
   logic             w_load;

   // Operand forwarding: data holds when no valid sample arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         if (valid_in) begin
            r_a <= a_in;
            r_b <= b_in;
         end
         r_valid <= valid_in;
         r_last  <= last_in & valid_in;
      end
   end

   multu8 u_mul (
      .i_a (r_a),
      .i_b (r_b),
      .o_p (w_p)
   );

   // A fresh window always starts from zero, independent of leftover values.
   assign w_acc_cur  = (r_state == S_IDLE) ? '0   : r_acc;
   assign w_cnt_cur  = (r_state == S_IDLE) ? '0   : r_cnt;
   assign w_ovf_cur  = (r_state == S_IDLE) ? 1'b0 : r_ovf;

   assign w_sum_full = SUM_W'(w_acc_cur) + SUM_W'(w_p);
   assign w_sum      = w_sum_full[ACC_W-1:0];
   assign w_ovf_n    = w_ovf_cur | w_sum_full[ACC_W];
   assign w_cnt_n    = (w_cnt_cur == {CNT_W{1'b1}}) ? w_cnt_cur
                                                    : w_cnt_cur + CNT_W'(1);
   assign w_load     = r_valid & r_last;

   // Accumulator FSM and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_res_data  <= '0;
         r_res_count <= '0;
         r_res_ovf   <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         if (r_valid) begin
            if (r_last) begin
               r_state     <= S_IDLE;
               r_acc       <= '0;
               r_cnt       <= '0;
               r_ovf       <= 1'b0;
               r_res_data  <= w_sum;
               r_res_count <= w_cnt_n;
               r_res_ovf   <= w_ovf_n;
            end else begin
               r_state <= S_ACC;
               r_acc   <= w_sum;
               r_cnt   <= w_cnt_n;
               r_ovf   <= w_ovf_n;
            end
         end

         // A load always wins over an accept in the same cycle.
         if (w_load) begin
            r_res_valid <= 1'b1;
         end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   // Sticky overrun; a new overrun event beats clr_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (w_load && r_res_valid && !res_ready) begin
         r_overrun <= 1'b1;
      end else if (clr_err) begin
         r_overrun <= 1'b0;
      end
   end

   assign a_out     = r_a;
   assign b_out     = r_b;
   assign valid_out = r_valid;
   assign last_out  = r_last;
   assign res_data  = r_res_data;
   assign res_count = r_res_count;
   assign res_ovf   = r_res_ovf;
   assign res_valid = r_res_valid;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_pe_mac8.sv
// ---------------------------------------------------------------------------
// tb_pe_mac8 - directed bench for pe_mac8. Two instances share all inputs:
// the default ACC_W=20 build and an ACC_W=8 build that exercises wrapping.
// ---------------------------------------------------------------------------
module tb_pe_mac8;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  a_in, b_in;
   logic        valid_in, last_in, res_ready, clr_err;

   logic [7:0]  a_out, b_out;
   logic        valid_out, last_out;
   logic [19:0] res_data;
   logic [7:0]  res_count;
   logic        res_ovf, res_valid, overrun;

   logic [7:0]  a_out8, b_out8;
   logic        valid_out8, last_out8;
   logic [7:0]  res_data8;
   logic [7:0]  res_count8;
   logic        res_ovf8, res_valid8, overrun8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pe_mac8 #(.ACC_W(20), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
      .valid_in(valid_in), .last_in(last_in),
      .a_out(a_out), .b_out(b_out), .valid_out(valid_out), .last_out(last_out),
      .res_data(res_data), .res_count(res_count), .res_ovf(res_ovf),
      .res_valid(res_valid), .res_ready(res_ready),
      .overrun(overrun), .clr_err(clr_err)
   );

   pe_mac8 #(.ACC_W(8), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
      .valid_in(valid_in), .last_in(last_in),
      .a_out(a_out8), .b_out(b_out8), .valid_out(valid_out8), .last_out(last_out8),
      .res_data(res_data8), .res_count(res_count8), .res_ovf(res_ovf8),
      .res_valid(res_valid8), .res_ready(res_ready),
      .overrun(overrun8), .clr_err(clr_err)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         n;        // samples in window, all with the same a/b
      int         exp_d20;
      logic       exp_o20;
      int         exp_d8;
      logic       exp_o8;
      int         exp_cnt;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b,
                        input logic v, input logic l);
      a_in = a; b_in = b; valid_in = v; last_in = l;
   endtask

   task automatic chk_res(input string tag, input int d, input int c,
                          input logic o, input logic v);
      chk({tag, " res_valid"}, int'(res_valid), int'(v));
      chk({tag, " res_data"},  int'(res_data),  d);
      chk({tag, " res_count"}, int'(res_count), c);
      chk({tag, " res_ovf"},   int'(res_ovf),   int'(o));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " a_out"},     int'(a_out),     0);
      chk({tag, " b_out"},     int'(b_out),     0);
      chk({tag, " valid_out"}, int'(valid_out), 0);
      chk({tag, " last_out"},  int'(last_out),  0);
      chk({tag, " res_data"},  int'(res_data),  0);
      chk({tag, " res_count"}, int'(res_count), 0);
      chk({tag, " res_ovf"},   int'(res_ovf),   0);
      chk({tag, " res_valid"}, int'(res_valid), 0);
      chk({tag, " overrun"},   int'(overrun),   0);
      chk({tag, " dut8 outs"},
          int'(a_out8) | int'(b_out8) | int'(valid_out8) | int'(last_out8) |
          int'(res_data8) | int'(res_count8) | int'(res_ovf8) |
          int'(res_valid8) | int'(overrun8), 0);
   endtask

   // One window of n identical samples, then check and consume the result.
   task automatic run_vec(input int k);
      string tag;
      tag = $sformatf("vec%0d", k);
      for (int i = 0; i < vecs[k].n; i++) begin
         drive(vecs[k].a, vecs[k].b, 1'b1, 1'(i == vecs[k].n - 1));
         tick();
         if (i < 2 || i == vecs[k].n - 1) begin
            chk({tag, " a_out"},     int'(a_out),     int'(vecs[k].a));
            chk({tag, " b_out"},     int'(b_out),     int'(vecs[k].b));
            chk({tag, " valid_out"}, int'(valid_out), 1);
            chk({tag, " last_out"},  int'(last_out),  int'(i == vecs[k].n - 1));
            if (i == vecs[k].n - 1)
               chk({tag, " res_valid early"}, int'(res_valid), 0);
         end
      end
      drive(8'd0, 8'd0, 1'b0, 1'b0);
      tick();
      chk_res(tag, vecs[k].exp_d20, vecs[k].exp_cnt, vecs[k].exp_o20, 1'b1);
      chk({tag, " d8 res_data"},  int'(res_data8),  vecs[k].exp_d8);
      chk({tag, " d8 res_ovf"},   int'(res_ovf8),   int'(vecs[k].exp_o8));
      chk({tag, " d8 res_count"}, int'(res_count8), vecs[k].exp_cnt);
      tick();  // held with no accept: must be stable
      chk_res({tag, " hold"}, vecs[k].exp_d20, vecs[k].exp_cnt, vecs[k].exp_o20, 1'b1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({tag, " accepted"}, int'(res_valid), 0);
      chk({tag, " overrun"},  int'(overrun),   0);
   endtask

   initial begin
      //          a    b    n    d20  o20 d8   o8  cnt
      vecs[0] = '{8'd3,   8'd5,   4,   60,  0, 60,  0, 4};
      vecs[1] = '{8'd200, 8'd3,   1,   88,  0, 88,  0, 1};
      vecs[2] = '{8'd16,  8'd16,  1,   0,   0, 0,   0, 1};
      vecs[3] = '{8'd255, 8'd255, 3,   3,   0, 3,   0, 3};
      vecs[4] = '{8'd7,   8'd9,   2,   126, 0, 126, 0, 2};
      vecs[5] = '{8'd15,  8'd15,  3,   675, 0, 163, 1, 3};
      vecs[6] = '{8'd1,   8'd1,   1,   1,   0, 1,   0, 1};
      vecs[7] = '{8'd100, 8'd100, 40,  640, 0, 128, 1, 40};
      vecs[8] = '{8'd1,   8'd1,   300, 300, 0, 44,  1, 255};

      rst = 1'b1;
      drive(8'd0, 8'd0, 1'b0, 1'b0);
      res_ready = 1'b0;
      clr_err   = 1'b0;
      tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();

      for (int k = 0; k < NV; k++) run_vec(k);

      // Back-pressure: second result overwrites the first.
      drive(8'd2, 8'd2, 1'b1, 1'b1); tick();
      drive(8'd3, 8'd3, 1'b1, 1'b1); tick();
      chk_res("bp first", 4, 1, 1'b0, 1'b1);
      chk("bp overrun pre", int'(overrun), 0);
      drive(8'd0, 8'd0, 1'b0, 1'b0); tick();
      chk_res("bp second", 9, 1, 1'b0, 1'b1);
      chk("bp overrun", int'(overrun), 1);
      tick();
      chk("bp overrun sticky", int'(overrun), 1);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("bp clr_err", int'(overrun), 0);
      chk("bp still valid", int'(res_valid), 1);
      res_ready = 1'b1; tick();
      chk("bp drained", int'(res_valid), 0);

      // Same windows with res_ready held: load+accept overlaps, no overrun.
      drive(8'd2, 8'd2, 1'b1, 1'b1); tick();
      drive(8'd3, 8'd3, 1'b1, 1'b1); tick();
      chk_res("rdy first", 4, 1, 1'b0, 1'b1);
      drive(8'd0, 8'd0, 1'b0, 1'b0); tick();
      chk_res("rdy second", 9, 1, 1'b0, 1'b1);
      chk("rdy overrun", int'(overrun), 0);
      tick();
      chk("rdy drained", int'(res_valid), 0);
      res_ready = 1'b0;

      // Overrun set and clr_err in the same cycle: set wins.
      drive(8'd1, 8'd1, 1'b1, 1'b1); tick();
      drive(8'd1, 8'd2, 1'b1, 1'b1); tick();
      clr_err = 1'b1;
      drive(8'd0, 8'd0, 1'b0, 1'b0); tick();
      clr_err = 1'b0;
      chk("set beats clr", int'(overrun), 1);
      chk("set beats clr data", int'(res_data), 2);
      clr_err = 1'b1; res_ready = 1'b1; tick();
      clr_err = 1'b0; res_ready = 1'b0;
      chk("clr after", int'(overrun), 0);

      // Gapped input, with a stray last_in while valid_in is low.
      drive(8'd1, 8'd10, 1'b1, 1'b0); tick();
      drive(8'd9, 8'd9, 1'b0, 1'b1);  tick();
      chk("gap a_out hold", int'(a_out), 1);
      chk("gap b_out hold", int'(b_out), 10);
      chk("gap valid_out", int'(valid_out), 0);
      chk("gap last_out ignored", int'(last_out), 0);
      drive(8'd2, 8'd10, 1'b1, 1'b0); tick();
      drive(8'd0, 8'd0, 1'b0, 1'b0);  tick(); tick();
      chk("gap no result", int'(res_valid), 0);
      drive(8'd3, 8'd10, 1'b1, 1'b1); tick();
      drive(8'd0, 8'd0, 1'b0, 1'b0);  tick();
      chk_res("gap", 60, 3, 1'b0, 1'b1);
      res_ready = 1'b1; tick(); res_ready = 1'b0;

      // Reset mid-window, with a pending result that must also be dropped.
      drive(8'd5, 8'd5, 1'b1, 1'b1); tick();
      drive(8'd4, 8'd4, 1'b1, 1'b0); tick();
      chk("rst pending", int'(res_valid), 1);
      tick();
      drive(8'd0, 8'd0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk_all_zero("rst async");
      tick();
      chk_all_zero("rst held");
      rst = 1'b0;
      tick();
      chk("rst no stale result", int'(res_valid), 0);
      drive(8'd2, 8'd2, 1'b1, 1'b1); tick();
      drive(8'd0, 8'd0, 1'b0, 1'b0); tick();
      chk_res("post-rst", 4, 1, 1'b0, 1'b1);
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      tick();
      chk("post-rst single", int'(res_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
